// File: rtl/load_unit_pkg.sv
// Shared load/store definitions: access type encodings, FSM states, defaults.
// Also provides the misalignment predicate used when LOAD_MISALIGN_TRAP_EN is defined.
package load_store_defs;

    // Same encoding as the store path's StoreType; 2'b11 also decodes as halfword.
    localparam logic [1:0] LOAD_WORD = 2'b00;
    localparam logic [1:0] LOAD_BYTE = 2'b01;
    localparam logic [1:0] LOAD_HALF = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } load_state_t;

    function automatic logic is_misaligned(input logic [1:0] load_type,
                                           input logic [1:0] addr_lo);
        return (load_type[1] && addr_lo[0]) ||
               (load_type == LOAD_WORD && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, memory-port and result handshakes of the load unit.
// slave = load_unit view; master = execute stage / memory side view.
interface load_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_type;
    logic              req_unsigned;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              result_valid;
    logic              result_ready;
    logic [31:0]       result_data;
    logic              result_err;

    modport slave (
        input  req_valid, req_addr, req_type, req_unsigned,
        input  mem_ready, mem_rvalid, mem_rdata,
        input  result_ready,
        output req_ready, mem_rd_en, mem_addr,
        output result_valid, result_data, result_err
    );

    modport master (
        output req_valid, req_addr, req_type, req_unsigned,
        output mem_ready, mem_rvalid, mem_rdata,
        output result_ready,
        input  req_ready, mem_rd_en, mem_addr,
        input  result_valid, result_data, result_err
    );
endinterface

// File: rtl/load_unit_extract.sv
// Combinational byte/halfword/word extraction with zero/sign extension,
// built from the shared mux2/mux4 cells.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

module mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = d0;
        case (sel)
            2'b01:   y = d1;
            2'b10:   y = d2;
            2'b11:   y = d3;
            default: y = d0;
        endcase
    end
endmodule

module load_extract (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  load_type,
    input  logic        is_unsigned,
    output logic [31:0] value
);
    logic [3:0]  byte_sign;
    logic [1:0]  half_sign;
    logic [31:0] byte_val;
    logic [31:0] half_val;

    // Extension is applied per lane before muxing so every mux bit is live.
    assign byte_sign[0] = rdata[7]  & ~is_unsigned;
    assign byte_sign[1] = rdata[15] & ~is_unsigned;
    assign byte_sign[2] = rdata[23] & ~is_unsigned;
    assign byte_sign[3] = rdata[31] & ~is_unsigned;
    assign half_sign[0] = rdata[15] & ~is_unsigned;
    assign half_sign[1] = rdata[31] & ~is_unsigned;

    mux4 #(.WIDTH(32)) u_byte_mux (
        .sel (addr_lo),
        .d0  ({{24{byte_sign[0]}}, rdata[7:0]}),
        .d1  ({{24{byte_sign[1]}}, rdata[15:8]}),
        .d2  ({{24{byte_sign[2]}}, rdata[23:16]}),
        .d3  ({{24{byte_sign[3]}}, rdata[31:24]}),
        .y   (byte_val)
    );

    mux2 #(.WIDTH(32)) u_half_mux (
        .sel (addr_lo[1]),
        .d0  ({{16{half_sign[0]}}, rdata[15:0]}),
        .d1  ({{16{half_sign[1]}}, rdata[31:16]}),
        .y   (half_val)
    );

    mux4 #(.WIDTH(32)) u_type_mux (
        .sel (load_type),
        .d0  (rdata),
        .d1  (byte_val),
        .d2  (half_val),
        .d3  (half_val),
        .y   (value)
    );
endmodule

// File: rtl/load_unit.sv
// Load unit: one outstanding aligned read, extraction/extension, timeout watchdog.
// Optional LOAD_MISALIGN_TRAP_EN: misaligned half/word loads return err without a memory read.
module load_unit
    import load_store_defs::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    load_unit_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    load_state_t        state, state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         type_q;
    logic               uns_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  res_data_q;
    logic               res_err_q;
    logic [31:0]        extracted;
    logic               timeout;
    logic               trap;

    load_extract u_extract (
        .rdata       (bus.mem_rdata),
        .addr_lo     (addr_q[1:0]),
        .load_type   (type_q),
        .is_unsigned (uns_q),
        .value       (extracted)
    );

`ifdef LOAD_MISALIGN_TRAP_EN
    assign trap = is_misaligned(bus.req_type, bus.req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // req_ready is gated by reset so every output reads 0 while reset is held.
    assign bus.req_ready    = (state == S_IDLE) && !reset;
    assign bus.mem_rd_en    = (state == S_REQ);
    assign bus.mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.result_valid = (state == S_DONE);
    assign bus.result_data  = res_data_q;
    assign bus.result_err   = res_err_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.req_valid) state_next = trap ? S_DONE : S_REQ;
            S_REQ:  if (bus.mem_ready) state_next = S_WAIT;
            S_WAIT: if (bus.mem_rvalid || timeout) state_next = S_DONE;
            S_DONE: if (bus.result_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            type_q     <= '0;
            uns_q      <= 1'b0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr;
                        type_q <= bus.req_type;
                        uns_q  <= bus.req_unsigned;
                        if (trap) begin
                            res_data_q <= '0;
                            res_err_q  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) cnt_q <= '0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Returned data takes priority over a coincident timeout.
                    if (bus.mem_rvalid) begin
                        res_data_q <= DATA_W'(extracted);
                        res_err_q  <= 1'b0;
                    end else if (timeout) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: expected results queued at request time,
// compared when the result handshake completes.
module tb_load_unit;
    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    load_unit_if #(.ADDR_W(32)) bus ();

    load_unit #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] t, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (t == 2'b00)      return w;
        else if (t == 2'b01) return u ? {24'b0, b} : {{24{b[7]}}, b};
        else                 return u ? {16'b0, h} : {{16{h[15]}}, h};
    endfunction

    // Result handshake monitor: pops the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.result_valid && bus.result_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_data", bus.result_data, e.data);
                check("result_err", {31'b0, bus.result_err}, {31'b0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rv_cycle: WAIT cycle index on which mem_rvalid is driven (-1 = never).
    task automatic do_load(input logic [31:0] addr, input logic [1:0] t, input logic u,
                           input logic [31:0] word, input int ready_lat, input int rv_cycle,
                           input int hold_lat, input logic [31:0] exp_d, input logic exp_e);
        int   n;
        int   cyc;
        logic got;
        sb.push_back('{data: exp_d, err: exp_e});
        bus.req_addr     = addr;
        bus.req_type     = t;
        bus.req_unsigned = u;
        bus.req_valid    = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        bus.req_valid = 1'b0;
        check("rd_en_req", {31'b0, bus.mem_rd_en}, 32'd1);
        check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
        for (int i = 0; i < ready_lat; i++) begin
            tick();
            check("rd_en_hold", {31'b0, bus.mem_rd_en}, 32'd1);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("rd_en_wait", {31'b0, bus.mem_rd_en}, 32'd0);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (i == rv_cycle) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = word;
            end
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            cyc = i + 1;
            if (bus.result_valid) got = 1'b1;
        end
        check("result_seen", {31'b0, got}, 32'd1);
        if (rv_cycle >= 0) check("rv_latency", cyc, rv_cycle + 1);
        else               check("timeout_cycles", cyc, TO);
        for (int i = 0; i < hold_lat; i++) begin
            tick();
            check("hold_valid", {31'b0, bus.result_valid}, 32'd1);
            check("hold_data", bus.result_data, exp_d);
            check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("valid_clr", {31'b0, bus.result_valid}, 32'd0);
        check("req_ready_back", {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd0);
        check({tag, "_rd_en"}, {31'b0, bus.mem_rd_en}, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_rvalid"}, {31'b0, bus.result_valid}, 32'd0);
        check({tag, "_rdata"}, bus.result_data, 32'd0);
        check({tag, "_rerr"}, {31'b0, bus.result_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        logic [1:0]  t;
        logic        u;
        checks = 0;
        errors = 0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_type     = '0;
        bus.req_unsigned = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;
        bus.result_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);

        // Extraction from 0x8899AABB.
        do_load(32'h102, 2'b01, 1'b0, 32'h8899AABB, 0, 0, 0, 32'hFFFFFF99, 1'b0);
        do_load(32'h103, 2'b01, 1'b1, 32'h8899AABB, 0, 0, 0, 32'h00000088, 1'b0);
        do_load(32'h102, 2'b10, 1'b0, 32'h8899AABB, 0, 0, 0, 32'hFFFF8899, 1'b0);
        do_load(32'h100, 2'b10, 1'b1, 32'h8899AABB, 0, 0, 0, 32'h0000AABB, 1'b0);
        do_load(32'h100, 2'b00, 1'b0, 32'h8899AABB, 0, 0, 0, 32'h8899AABB, 1'b0);
        do_load(32'h100, 2'b01, 1'b0, 32'h8899AABB, 0, 1, 0, 32'hFFFFFFBB, 1'b0);
        do_load(32'h101, 2'b01, 1'b1, 32'h8899AABB, 0, 0, 0, 32'h000000AA, 1'b0);
        do_load(32'h100, 2'b11, 1'b1, 32'h8899AABB, 0, 0, 0, 32'h0000AABB, 1'b0);
        do_load(32'h100, 2'b10, 1'b0, 32'h12345678, 0, 0, 0, 32'h00005678, 1'b0);
        do_load(32'h101, 2'b01, 1'b0, 32'h12345678, 0, 0, 0, 32'h00000056, 1'b0);
        do_load(32'h100, 2'b00, 1'b1, 32'h80000001, 0, 0, 0, 32'h80000001, 1'b0);

        // Slow memory accept, late data, stalled consumer.
        do_load(32'h100, 2'b00, 1'b0, 32'h8899AABB, 5, 1, 4, 32'h8899AABB, 1'b0);

        // Timeout, then data arriving on the timeout cycle.
        do_load(32'h100, 2'b00, 1'b0, 32'h8899AABB, 0, -1, 2, 32'h00000000, 1'b1);
        do_load(32'h102, 2'b10, 1'b1, 32'h8899AABB, 0, TO - 1, 0, 32'h00008899, 1'b0);
        do_load(32'h100, 2'b00, 1'b0, 32'hCAFEF00D, 0, TO - 2, 0, 32'hCAFEF00D, 1'b0);

        // Reset mid-WAIT, then a stray mem_rvalid.
        bus.req_addr  = 32'h104;
        bus.req_type  = 2'b00;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        tick();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_no_result", {31'b0, bus.result_valid}, 32'd0);
            check("stray_no_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
            tick();
        end
        check("post_reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
        do_load(32'h100, 2'b00, 1'b0, 32'h8899AABB, 0, 2, 0, 32'h8899AABB, 1'b0);

`ifdef LOAD_MISALIGN_TRAP_EN
        sb.push_back('{data: 32'h0, err: 1'b1});
        bus.req_addr     = 32'h101;
        bus.req_type     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_valid    = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("trap_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        check("trap_valid", {31'b0, bus.result_valid}, 32'd1);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("trap_rd_en_after", {31'b0, bus.mem_rd_en}, 32'd0);
        check("trap_idle", {31'b0, bus.req_ready}, 32'd1);
`else
        do_load(32'h101, 2'b00, 1'b0, 32'h8899AABB, 0, 0, 0, 32'h8899AABB, 1'b0);
        do_load(32'h103, 2'b10, 1'b0, 32'h8899AABB, 0, 0, 0, 32'hFFFF8899, 1'b0);
`endif

        // Randomised aligned loads against a shift-based reference.
        for (int k = 0; k < 10; k++) begin
            w = $urandom;
            t = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            a = 32'h200 + 32'($urandom_range(0, 63));
            if (t == 2'b00) a[1:0] = 2'b00;
            else if (t[1]) a[0] = 1'b0;
            do_load(a, t, u, w, $urandom_range(0, 2), $urandom_range(0, 3), 0,
                    ref_load(w, a[1:0], t, u), 1'b0);
        end

        tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side counterpart to the store merge path: issues word-aligned reads to data memory and returns LB/LBU/LH/LHU/LW results to the core.
- Extracts the addressed byte or halfword and zero- or sign-extends it.
- Sits between the execute stage and the data memory port.
- Uses a valid/ready request/response handshake with variable memory latency and a timeout watchdog.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before error; minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_type  in  2  00 word, 01 byte, 1x halfword; same encoding as StoreType.
- req_unsigned  in  1  1 = zero-extend (LBU/LHU); ignored for word.
- mem_rd_en  out  1  read request to memory.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}.
- mem_ready  in  1  memory accepts the read.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  full aligned word.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result_data  out  32  extended load value.
- result_err  out  1  timeout (or misalign when the option is enabled) accompanies this result.

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, latched fields 0, timeout counter 0.
- A late mem_rvalid after reset is ignored, because the unit is in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: req_ready=1. On req_valid, latch addr, type and unsigned, then go to REQ.
  - REQ: mem_rd_en=1 and mem_addr driven from the latched address. When mem_ready=1, clear the counter and go to WAIT. mem_rvalid is ignored in REQ; the earliest valid return is the cycle after acceptance.
  - WAIT: counter increments each cycle.
    - mem_rvalid=1: register the extracted data, result_err=0, go to DONE.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: result_data=0, result_err=1, go to DONE.
    - If mem_rvalid and timeout occur in the same cycle, data wins.
  - DONE: result_valid=1, with result_data and result_err held stable. When result_ready=1, clear result_valid and go to IDLE. No new request is accepted in the same cycle.
- Latency:
  - Request accepted at edge N.
  - mem_rd_en is high from N.
  - result_valid rises one cycle after the mem_rvalid cycle.
  - Minimum request-to-result: 3 cycles.
- Extraction uses latched addr[1:0]:
  - Byte: byte k = rdata[8k+7:8k]; bit 7 replicated (signed) or zeros (unsigned).
  - Halfword: addr[1]=0 gives rdata[15:0], addr[1]=1 gives rdata[31:16]; addr[0] ignored. Extend from bit 15.
  - Word: rdata unchanged; addr[1:0] ignored.
- Only one outstanding read at a time. A mem_rvalid outside WAIT is dropped.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - On acceptance of a misaligned request, go IDLE→DONE directly.
  - mem_rd_en is never asserted; result_data=0, result_err=1.
- Undefined: no check. Alignment bits are silently ignored as described above.

Decomposition:
- Shared package/header load_store_defs holds:
  - LOAD_WORD=2'b00, LOAD_BYTE=2'b01, LOAD_HALF=2'b10 (shared with the store path's StoreType);
  - FSM state encodings;
  - default TIMEOUT_CYCLES.
- One sub-module, load_extract: purely combinational (rdata, addr[1:0], type, unsigned → 32-bit value), built from the existing mux4/mux2 with WIDTH=32. It is unit-testable on its own.

Test Plan:
1. mem word 0x8899AABB. LB addr 0x102 → result 0xFFFFFF99, err 0. LBU addr 0x103 → 0x00000088.
2. Same word. LH addr 0x102 → 0xFFFF8899. LHU addr 0x100 → 0x0000AABB. LW addr 0x100 → 0x8899AABB. mem_addr=0x100 throughout.
3. mem_ready held low 5 cycles, then rvalid 7 cycles after acceptance → mem_rd_en held through REQ, correct data, result_valid exactly one cycle after rvalid. result_ready held low 4 cycles → data stable, req_ready=0.
4. mem_rvalid never asserted, TIMEOUT_CYCLES=8 → result_valid with err=1 and data=0 after 8 WAIT cycles. Variant: rvalid on the timeout cycle → err=0, data valid.
5. reset pulsed mid-WAIT, then stray mem_rvalid → all outputs 0, state IDLE, no result_valid. Next LW returns correctly.
6. With LOAD_MISALIGN_TRAP_EN: LW addr 0x101 → mem_rd_en never high, result_err=1, data=0 one cycle later. Without the macro → returns the word at 0x100.
